// File: rtl/apb_fabric_pkg.sv
// apb_fabric_pkg: shared state encoding, default geometry and index-width helper for the APB fabric.
package apb_fabric_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;
   localparam int DEF_REGION_LOG2 = 12;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps an address onto a fixed-size completer region, flags anything outside the bank.
module apb_addr_decoder
   import apb_fabric_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int REGION_LOG2 = DEF_REGION_LOG2,
   parameter int IDX_W = idx_w(NUM_SLAVES)
) (
   input  logic [ADDR_W-1:0] paddr,
   output logic              hit,
   output logic [IDX_W-1:0]  idx
);
   logic [ADDR_W-1:0] off, region;
   assign off = paddr - BASE_ADDR;
   assign region = off >> REGION_LOG2;
   assign hit = paddr >= BASE_ADDR && region < ADDR_W'(NUM_SLAVES);
   assign idx = region[IDX_W-1:0];
endmodule

// File: rtl/apb_nslave_fabric.sv
// apb_nslave_fabric: one APB requester fanned out to NUM_SLAVES completers with a registered SETUP/ACCESS stage.
// Defining APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYC cycles and reports expiry as an error.
module apb_nslave_fabric
   import apb_fabric_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int REGION_LOG2 = DEF_REGION_LOG2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic                         pwrite,
   input  logic                         psel,
   input  logic                         penable,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [ADDR_W-1:0]            paddr_s,
   output logic [DATA_W-1:0]            pwdata_s,
   output logic                         pwrite_s,
   output logic [NUM_SLAVES-1:0]        psel_s,
   output logic                         penable_s,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata_s,
   input  logic [NUM_SLAVES-1:0]        pready_s,
   input  logic [NUM_SLAVES-1:0]        pslverr_s
);
   localparam int IDX_W = idx_w(NUM_SLAVES);
   state_t state, state_nx;
   logic [IDX_W-1:0] idx, dec_idx;
   logic dec_hit, setup, done, expired, err_q;
   logic [DATA_W-1:0] prdata_q;

   apb_addr_decoder #(
      .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
      .REGION_LOG2(REGION_LOG2), .IDX_W(IDX_W)
   ) u_dec (.paddr(paddr), .hit(dec_hit), .idx(dec_idx));

   assign setup = state == IDLE && psel && !penable;
   // only the selected completer's ready is honoured
   assign done = state == ACCESS && pready_s[idx];

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= state == ACCESS ? cnt + CNT_W'(1) : '0;
   assign expired = !done && cnt == CNT_W'(TIMEOUT_CYC - 1);
`else
   localparam int unused_timeout = TIMEOUT_CYC;
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         idx <= '0;
         paddr_s <= '0;
         pwdata_s <= '0;
         pwrite_s <= 1'b0;
         prdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (setup) begin
            paddr_s <= paddr;
            pwdata_s <= pwdata;
            pwrite_s <= pwrite;
            idx <= dec_idx;
         end
         if (done) begin
            prdata_q <= pwrite_s ? '0 : prdata_s[idx*DATA_W +: DATA_W];
            err_q <= pslverr_s[idx];
         end
      end

   always_comb begin
      state_nx = state;
      psel_s = '0;
      penable_s = 1'b0;
      pready = 1'b0;
      pslverr = 1'b0;
      prdata = '0;
      case (state)
         IDLE: if (setup) state_nx = dec_hit ? SETUP : ERR;
         SETUP: begin
            psel_s = NUM_SLAVES'(1) << idx;
            state_nx = ACCESS;
         end
         ACCESS: begin
            psel_s = NUM_SLAVES'(1) << idx;
            penable_s = 1'b1;
            state_nx = done ? RESP : expired ? ERR : ACCESS;
         end
         RESP: begin
            pready = 1'b1;
            pslverr = err_q;
            prdata = prdata_q;
            state_nx = IDLE;
         end
         default: begin
            pready = 1'b1;
            pslverr = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end
endmodule
